// File: rtl/filter_iq_axis_stall_detector_pkg.sv
// Shared types and helpers for the filter_iq stall detector.
// Optional stall statistics are enabled with FILTER_IQ_STALL_STATS_EN.
package filter_iq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        BLOCKED  = 2'd2
    } stall_state_t;

    localparam int unsigned STALL_CNT_W_DEFAULT = 16;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        if (w >= 32) begin
            max_v = '1;
        end else begin
            max_v = (32'd1 << w) - 32'd1;
        end
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/filter_iq_axis_stall_detector_if.sv
// tvalid/tready bundle of the monitored filter_iq stream ports.
interface filter_iq_axis_stall_detector_if #(
    parameter int unsigned N_PORTS = 2
);
    logic [N_PORTS-1:0] axis_tvalid;
    logic [N_PORTS-1:0] axis_tready;

    modport master (output axis_tvalid, output axis_tready);
    modport slave  (input  axis_tvalid, input  axis_tready);
endinterface

// File: rtl/filter_iq_axis_stall_detector_port.sv
// One monitored port: stall run-length FSM plus optional stall event counter.
// Stats counter exists only when FILTER_IQ_STALL_STATS_EN is defined.
module filter_iq_stall_port
    import filter_iq_pkg::*;
#(
    parameter int unsigned CNT_W    = STALL_CNT_W_DEFAULT,
    parameter bit          IS_INPUT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tvalid,
    input  logic             tready,
    input  logic [CNT_W-1:0] threshold,
    output logic             blocked,
    output logic             blocked_next_c
`ifdef FILTER_IQ_STALL_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_count
`endif
);

    stall_state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             cond_c;
    logic             thr_zero_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Input ports stall when starved, output ports when back-pressured.
    assign cond_c     = IS_INPUT ? (tready & ~tvalid) : (tvalid & ~tready);
    assign thr_zero_c = (threshold == '0);
    assign cnt_inc_c  = CNT_W'(sat_inc(32'(cnt), CNT_W));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            blocked <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            blocked <= (state_next == BLOCKED);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (cond_c && !thr_zero_c) begin
                    cnt_next   = CNT_W'(1);
                    state_next = (threshold == CNT_W'(1)) ? BLOCKED : COUNTING;
                end
            end
            COUNTING: begin
                if (!cond_c || thr_zero_c) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc_c;
                    if (cnt_inc_c >= threshold) begin
                        state_next = BLOCKED;
                    end
                end
            end
            BLOCKED: begin
                if (!cond_c || thr_zero_c) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign blocked_next_c = (state_next == BLOCKED);

`ifdef FILTER_IQ_STALL_STATS_EN
    // Counts entries into BLOCKED; sticks at all-ones until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_count <= '0;
        end else if ((state_next == BLOCKED) && (state != BLOCKED)) begin
            stat_count <= CNT_W'(sat_inc(32'(stat_count), CNT_W));
        end
    end
`endif

endmodule

// File: rtl/filter_iq_axis_stall_detector.sv
// Per-port AXI-Stream stall detector feeding the filter_iq deadlock monitor.
// Define FILTER_IQ_STALL_STATS_EN to add the stall_count statistics port.
module filter_iq_axis_stall_detector
    import filter_iq_pkg::*;
#(
    parameter int unsigned        N_PORTS       = 2,
    parameter int unsigned        CNT_W         = STALL_CNT_W_DEFAULT,
    parameter logic [N_PORTS-1:0] PORT_IS_INPUT = N_PORTS'(1)
) (
    input  logic                              clock,
    input  logic                              reset,
    filter_iq_axis_stall_detector_if.slave    axis,
    input  logic [CNT_W-1:0]                  threshold,
    output logic [N_PORTS-1:0]                axis_block_sigs,
    output logic                              any_block
`ifdef FILTER_IQ_STALL_STATS_EN
    ,
    output logic [N_PORTS*CNT_W-1:0]          stall_count
`endif
);

    logic [N_PORTS-1:0] next_flags_c;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        filter_iq_stall_port #(
            .CNT_W    (CNT_W),
            .IS_INPUT (PORT_IS_INPUT[i])
        ) u_port (
            .clock          (clock),
            .reset          (reset),
            .tvalid         (axis.axis_tvalid[i]),
            .tready         (axis.axis_tready[i]),
            .threshold      (threshold),
            .blocked        (axis_block_sigs[i]),
            .blocked_next_c (next_flags_c[i])
`ifdef FILTER_IQ_STALL_STATS_EN
            ,
            .stat_count     (stall_count[i*CNT_W +: CNT_W])
`endif
        );
    end

    // Built from next-state flags so it lines up with axis_block_sigs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_block <= 1'b0;
        end else begin
            any_block <= |next_flags_c;
        end
    end

endmodule

// File: tb/tb_filter_iq_axis_stall_detector.sv
// Randomised and directed bench for filter_iq_axis_stall_detector (16-bit and 4-bit counter builds).
module tb_filter_iq_axis_stall_detector;
    import filter_iq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] thr16;
    logic [3:0]  thr4;
    logic [1:0]  blk0, blk1;
    logic        any0, any1;
`ifdef FILTER_IQ_STALL_STATS_EN
    logic [31:0] sc0;
    logic [7:0]  sc1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference: consecutive-stall run length, blocked flag, blocked-entry count.
    int unsigned m_run   [2][2];
    int unsigned m_stats [2][2];
    bit          m_blk   [2][2];

    always #5 clock = ~clock;

    filter_iq_axis_stall_detector_if #(.N_PORTS(2)) axis ();

    filter_iq_axis_stall_detector #(.N_PORTS(2), .CNT_W(16), .PORT_IS_INPUT(2'b01)) dut16 (
        .clock           (clock),
        .reset           (reset),
        .axis            (axis),
        .threshold       (thr16),
        .axis_block_sigs (blk0),
        .any_block       (any0)
`ifdef FILTER_IQ_STALL_STATS_EN
        ,
        .stall_count     (sc0)
`endif
    );

    filter_iq_axis_stall_detector #(.N_PORTS(2), .CNT_W(4), .PORT_IS_INPUT(2'b01)) dut4 (
        .clock           (clock),
        .reset           (reset),
        .axis            (axis),
        .threshold       (thr4),
        .axis_block_sigs (blk1),
        .any_block       (any1)
`ifdef FILTER_IQ_STALL_STATS_EN
        ,
        .stall_count     (sc1)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_flags(input int d);
        return {logic'(m_blk[d][1]), logic'(m_blk[d][0])};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                m_run[d][p]   = 0;
                m_stats[d][p] = 0;
                m_blk[d][p]   = 1'b0;
            end
    endtask

    task automatic model_step();
        logic [1:0]  tv, tr;
        int unsigned th, mx;
        bit          c, nb;
        tv = axis.axis_tvalid;
        tr = axis.axis_tready;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                th = (d == 0) ? 32'(thr16) : 32'(thr4);
                mx = (d == 0) ? 32'd65535 : 32'd15;
                c  = (p == 0) ? (tr[p] & ~tv[p]) : (tv[p] & ~tr[p]);
                if (c && th != 0) begin
                    if (m_run[d][p] < mx) m_run[d][p]++;
                    nb = m_blk[d][p] || (m_run[d][p] >= th);
                end else begin
                    m_run[d][p] = 0;
                    nb = 1'b0;
                end
                if (nb && !m_blk[d][p] && m_stats[d][p] < mx) m_stats[d][p]++;
                m_blk[d][p] = nb;
            end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    initial forever begin
        @(negedge clock);
        check("blk16", 32'(blk0), 32'(m_flags(0)));
        check("any16", 32'(any0), 32'(|m_flags(0)));
        check("blk4",  32'(blk1), 32'(m_flags(1)));
        check("any4",  32'(any1), 32'(|m_flags(1)));
`ifdef FILTER_IQ_STALL_STATS_EN
        for (int p = 0; p < 2; p++) begin
            check("stats16", 32'(sc0[p*16 +: 16]), m_stats[0][p]);
            check("stats4",  32'(sc1[p*4 +: 4]),   m_stats[1][p]);
        end
`endif
    end

    // Set inputs, then let n rising edges pass; returns 2 time units after the last edge.
    task automatic drive(input logic [1:0] tv, input logic [1:0] tr, input int n);
        axis.axis_tvalid = tv;
        axis.axis_tready = tr;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic set_thr(input logic [15:0] t16, input logic [3:0] t4);
        thr16 = t16;
        thr4  = t4;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #3 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        axis.axis_tvalid = 2'b00;
        axis.axis_tready = 2'b00;
        set_thr(16'd0, 4'd0);
        #8;
        check("rst_blk", 32'(blk0), 32'd0);
        check("rst_any", 32'(any0), 32'd0);
`ifdef FILTER_IQ_STALL_STATS_EN
        check("rst_stats", sc0, 32'd0);
`endif
        #9 reset = 1'b0;

        // Input port starved: flag after the 4th edge, clears one edge after tvalid.
        set_thr(16'd4, 4'd4);
        drive(2'b00, 2'b01, 3);
        check("starve_3", 32'(blk0), 32'b00);
        drive(2'b00, 2'b01, 1);
        check("starve_4", 32'(blk0), 32'b01);
        check("starve_any", 32'(any0), 32'd1);
        drive(2'b00, 2'b01, 6);
        check("starve_10", 32'(blk0), 32'b01);
        drive(2'b01, 2'b01, 1);
        check("starve_clr", 32'(blk0), 32'b00);
        check("starve_any_clr", 32'(any0), 32'd0);

        // Output port: a handshake in the middle restarts the count.
        drive(2'b10, 2'b00, 3);
        drive(2'b10, 2'b10, 1);
        drive(2'b10, 2'b00, 3);
        check("gap_noflag", 32'(blk0), 32'b00);
        drive(2'b00, 2'b00, 2);

        // Threshold 0 disables; enabling mid-stall starts counting from then.
        set_thr(16'd0, 4'd0);
        drive(2'b10, 2'b01, 100);
        check("thr0", 32'(blk0), 32'b00);
        check("thr0_any", 32'(any0), 32'd0);
        set_thr(16'd5, 4'd5);
        drive(2'b10, 2'b01, 4);
        check("thr5_4", 32'(blk0), 32'b00);
        drive(2'b10, 2'b01, 1);
        check("thr5_5", 32'(blk0), 32'b11);
        drive(2'b00, 2'b00, 2);

        // Lowering threshold below the run length blocks on the next edge; async reset.
        set_thr(16'd20, 4'd15);
        drive(2'b00, 2'b01, 12);
        check("thr20_12", 32'(blk0), 32'b00);
        set_thr(16'd8, 4'd8);
        drive(2'b00, 2'b01, 1);
        check("thr_lower", 32'(blk0), 32'b01);
        check("thr_lower4", 32'(blk1), 32'b01);
        #1 reset = 1'b1;
        #1;
        check("async_rst_blk", 32'(blk0), 32'd0);
        check("async_rst_any", 32'(any0), 32'd0);
        #2 reset = 1'b0;
        drive(2'b00, 2'b01, 7);
        check("restart_7", 32'(blk0), 32'b00);
        drive(2'b00, 2'b01, 1);
        check("restart_8", 32'(blk0), 32'b01);
        drive(2'b00, 2'b00, 2);

        // Stall events: three separate 5-cycle stalls at threshold 2.
        pulse_reset();
        set_thr(16'd2, 4'd2);
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 2'b01, 5);
            drive(2'b00, 2'b00, 2);
        end
`ifdef FILTER_IQ_STALL_STATS_EN
        check("stats_p0", 32'(sc0[15:0]), 32'd3);
        check("stats_p1", 32'(sc0[31:16]), 32'd0);
`endif
        // 20 single-cycle events at threshold 1: the 4-bit counter saturates.
        pulse_reset();
        set_thr(16'd1, 4'd1);
        for (int k = 0; k < 20; k++) begin
            drive(2'b00, 2'b01, 1);
            drive(2'b00, 2'b00, 1);
        end
`ifdef FILTER_IQ_STALL_STATS_EN
        check("stats_sat4", 32'(sc1[3:0]), 32'd15);
        check("stats_20", 32'(sc0[15:0]), 32'd20);
`endif
        // All-ones threshold on the 4-bit build is still reachable.
        set_thr(16'd15, 4'd15);
        drive(2'b00, 2'b01, 14);
        check("max_thr_14", 32'(blk1), 32'b00);
        drive(2'b00, 2'b01, 1);
        check("max_thr_15", 32'(blk1), 32'b01);
        drive(2'b00, 2'b00, 2);

        // Both ports together, then release port 1 only.
        set_thr(16'd3, 4'd3);
        drive(2'b10, 2'b01, 3);
        check("both_3", 32'(blk0), 32'b11);
        drive(2'b00, 2'b01, 1);
        check("rel_p1", 32'(blk0), 32'b01);
        check("rel_p1_any", 32'(any0), 32'd1);
        drive(2'b00, 2'b00, 2);

        // Randomised segments with drifting thresholds and occasional resets.
        for (int s = 0; s < 300; s++) begin
            logic [1:0] tv, tr;
            if ($urandom_range(0, 99) < 50) begin
                tv = 2'b10;
                tr = 2'b01;
                if ($urandom_range(0, 3) == 0) tv[1] = 1'b0;
                if ($urandom_range(0, 3) == 0) tr[0] = 1'b0;
            end else begin
                tv = 2'($urandom);
                tr = 2'($urandom);
            end
            if ($urandom_range(0, 99) < 20)
                set_thr(16'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) < 2) pulse_reset();
            drive(tv, tr, $urandom_range(1, 25));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
